// File: rtl/quad_encoder_mc_if.sv
// Bus bundle for the multi-channel quadrature decoder: raw encoder inputs, per-channel
// configuration, and the counter/flag outputs.
interface quad_encoder_mc_if #(
   parameter int CH_NUM    = 4,
   parameter int CNT_WIDTH = 32
);
   logic [CH_NUM-1:0]           enc_a, enc_b, enc_z;
   logic [CH_NUM-1:0]           pol_a, pol_b, pol_z;
   logic [CH_NUM-1:0]           ch_en, dir_inv, z_clr_en;
   logic [2*CH_NUM-1:0]         dec_mode;
   logic [CH_NUM-1:0]           pos_clr, flag_clr;
   logic [CH_NUM*CNT_WIDTH-1:0] position, z_capture;
   logic [CH_NUM-1:0]           err_flag, ovf_flag, z_flag, dir;

   modport master (
      output enc_a, enc_b, enc_z, pol_a, pol_b, pol_z, ch_en, dir_inv, z_clr_en,
             dec_mode, pos_clr, flag_clr,
      input  position, z_capture, err_flag, ovf_flag, z_flag, dir
   );

   modport slave (
      input  enc_a, enc_b, enc_z, pol_a, pol_b, pol_z, ch_en, dir_inv, z_clr_en,
             dec_mode, pos_clr, flag_clr,
      output position, z_capture, err_flag, ovf_flag, z_flag, dir
   );
endinterface

// File: rtl/quad_encoder_mc.sv
// Multi-channel quadrature encoder decoder: per-channel glitch filter, x1/x2/x4 decode,
// signed wrapping position counter, index capture and sticky status flags.
module quad_encoder_mc #(
   parameter int CH_NUM     = 4,
   parameter int CNT_WIDTH  = 32,
   parameter int FILTER_LEN = 9
) (
   input logic               sys_clk,
   input logic               sys_rst_n,
   quad_encoder_mc_if.slave  bus
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
   localparam logic [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // Filter output only moves once the whole history agrees.
   function automatic logic filt_next(input logic [FILTER_LEN-1:0] sh, input logic cur);
      if (&sh)       return 1'b1;
      else if (~|sh) return 1'b0;
      else           return cur;
   endfunction

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      logic [FILTER_LEN-1:0] sh_a_q, sh_b_q, sh_z_q;
      logic                  filt_a_q, filt_b_q, filt_z_q;
      logic                  prev_a_q, prev_b_q, prev_z_q;
      logic                  pclr_q1, pclr_q2, fclr_q1, fclr_q2;
      logic [CNT_WIDTH-1:0]  pos_q, pos_d, zcap_q, zcap_d;
      logic                  err_q, err_d, ovf_q, ovf_d, zf_q, zf_d, dir_q, dir_d;
      logic                  a_in, b_in, z_in, a_chg, b_chg, z_rise;
      logic                  step_evt, cnt, up, wrap, pclr_rise, fclr_rise;

      always_comb begin
         a_in      = bus.enc_a[i] ~^ bus.pol_a[i];
         b_in      = bus.enc_b[i] ~^ bus.pol_b[i];
         z_in      = bus.enc_z[i] ~^ bus.pol_z[i];
         a_chg     = filt_a_q ^ prev_a_q;
         b_chg     = filt_b_q ^ prev_b_q;
         z_rise    = filt_z_q & ~prev_z_q;
         pclr_rise = pclr_q1 & ~pclr_q2;
         fclr_rise = fclr_q1 & ~fclr_q2;

         unique case (bus.dec_mode[2*i +: 2])
            2'b01:   step_evt = a_chg & ~b_chg;
            2'b10:   step_evt = a_chg & ~b_chg & filt_a_q;
            default: step_evt = a_chg ^ b_chg;
         endcase

         // A leading B (A rises while B low) counts up; also gives x1 its +1-when-B-low rule.
         up   = (filt_a_q ^ prev_b_q) ^ bus.dir_inv[i];
         cnt  = bus.ch_en[i] & step_evt;
         wrap = cnt & (up ? (pos_q == CNT_MAX) : (pos_q == CNT_MIN));

         pos_d = pos_q;
         if (pclr_rise)                         pos_d = '0;
         else if (z_rise && bus.z_clr_en[i])    pos_d = '0;
         else if (cnt)                          pos_d = up ? pos_q + CNT_ONE : pos_q - CNT_ONE;

         zcap_d = z_rise ? pos_q : zcap_q;
         dir_d  = cnt ? up : dir_q;
         err_d  = (a_chg & b_chg) | (err_q & ~fclr_rise);
         ovf_d  = wrap | (ovf_q & ~fclr_rise);
         zf_d   = z_rise | (zf_q & ~fclr_rise);
      end

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_z_q   <= '0;
            filt_a_q <= 1'b0;
            filt_b_q <= 1'b0;
            filt_z_q <= 1'b0;
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
            prev_z_q <= 1'b0;
            pclr_q1  <= 1'b0;
            pclr_q2  <= 1'b0;
            fclr_q1  <= 1'b0;
            fclr_q2  <= 1'b0;
            pos_q    <= '0;
            zcap_q   <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zf_q     <= 1'b0;
            dir_q    <= 1'b0;
         end else begin
            sh_a_q   <= {sh_a_q[FILTER_LEN-2:0], a_in};
            sh_b_q   <= {sh_b_q[FILTER_LEN-2:0], b_in};
            sh_z_q   <= {sh_z_q[FILTER_LEN-2:0], z_in};
            filt_a_q <= filt_next(sh_a_q, filt_a_q);
            filt_b_q <= filt_next(sh_b_q, filt_b_q);
            filt_z_q <= filt_next(sh_z_q, filt_z_q);
            prev_a_q <= filt_a_q;
            prev_b_q <= filt_b_q;
            prev_z_q <= filt_z_q;
            pclr_q1  <= bus.pos_clr[i];
            pclr_q2  <= pclr_q1;
            fclr_q1  <= bus.flag_clr[i];
            fclr_q2  <= fclr_q1;
            pos_q    <= pos_d;
            zcap_q   <= zcap_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            zf_q     <= zf_d;
            dir_q    <= dir_d;
         end
      end

      assign bus.position[i*CNT_WIDTH +: CNT_WIDTH]  = pos_q;
      assign bus.z_capture[i*CNT_WIDTH +: CNT_WIDTH] = zcap_q;
      assign bus.err_flag[i] = err_q;
      assign bus.ovf_flag[i] = ovf_q;
      assign bus.z_flag[i]   = zf_q;
      assign bus.dir[i]      = dir_q;
   end
endmodule

// File: tb/tb_quad_encoder_mc.sv
// Directed bench for quad_encoder_mc: table of decode-mode vectors on channel 0 plus
// hand-written glitch, wrap, index, error and reset sequences.
module tb_quad_encoder_mc;
   localparam int CH = 4;
   localparam int CW = 8;
   localparam int FL = 9;

   logic sys_clk = 1'b0;
   logic sys_rst_n;

   quad_encoder_mc_if #(.CH_NUM(CH), .CNT_WIDTH(CW)) bus ();

   quad_encoder_mc #(.CH_NUM(CH), .CNT_WIDTH(CW), .FILTER_LEN(FL)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;
   int st[CH];

   typedef struct {
      logic [1:0] mode;
      bit         inv;
      bit         clr;
      int         n;
      int         exp_pos;
      int         exp_dir;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int pos_of(input int ch);
      logic [CW-1:0] v;
      v = bus.position[ch*CW +: CW];
      return int'($signed(v));
   endfunction

   function automatic int zcap_of(input int ch);
      logic [CW-1:0] v;
      v = bus.z_capture[ch*CW +: CW];
      return int'($signed(v));
   endfunction

   // Gray sequence with A leading B: 00 -> 10 -> 11 -> 01.
   task automatic drive_ab(input int ch);
      bus.enc_a[ch] = (st[ch] == 1) || (st[ch] == 2);
      bus.enc_b[ch] = (st[ch] >= 2);
   endtask

   task automatic step(input int ch, input bit fwd);
      st[ch] = fwd ? (st[ch] + 1) % 4 : (st[ch] + 3) % 4;
      drive_ab(ch);
      repeat (10) @(negedge sys_clk);
   endtask

   task automatic steps(input int ch, input int n);
      int m;
      m = (n < 0) ? -n : n;
      for (int k = 0; k < m; k++) step(ch, n > 0);
      repeat (12) @(negedge sys_clk);
   endtask

   task automatic pulse_pos_clr(input int ch);
      bus.pos_clr[ch] = 1'b1;
      repeat (3) @(negedge sys_clk);
      bus.pos_clr[ch] = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic pulse_flag_clr(input int ch);
      bus.flag_clr[ch] = 1'b1;
      repeat (3) @(negedge sys_clk);
      bus.flag_clr[ch] = 1'b0;
      @(negedge sys_clk);
   endtask

   initial begin
      vecs[0] = '{mode: 2'b00, inv: 1'b0, clr: 1'b1, n:  40, exp_pos:  40, exp_dir: 1};
      vecs[1] = '{mode: 2'b00, inv: 1'b0, clr: 1'b0, n: -40, exp_pos:   0, exp_dir: 0};
      vecs[2] = '{mode: 2'b01, inv: 1'b0, clr: 1'b1, n:  40, exp_pos:  20, exp_dir: 1};
      vecs[3] = '{mode: 2'b10, inv: 1'b0, clr: 1'b1, n:  40, exp_pos:  10, exp_dir: 1};
      vecs[4] = '{mode: 2'b01, inv: 1'b1, clr: 1'b1, n:  40, exp_pos: -20, exp_dir: 0};
      vecs[5] = '{mode: 2'b10, inv: 1'b1, clr: 1'b1, n:  40, exp_pos: -10, exp_dir: 0};
      vecs[6] = '{mode: 2'b11, inv: 1'b0, clr: 1'b1, n:   4, exp_pos:   4, exp_dir: 1};
      vecs[7] = '{mode: 2'b10, inv: 1'b0, clr: 1'b1, n: -40, exp_pos: -10, exp_dir: 0};

      for (int c = 0; c < CH; c++) st[c] = 0;
      bus.enc_a    = '0;
      bus.enc_b    = '0;
      bus.enc_z    = '0;
      bus.pol_a    = '1;
      bus.pol_b    = '1;
      bus.pol_z    = '1;
      bus.ch_en    = '1;
      bus.dir_inv  = '0;
      bus.z_clr_en = '0;
      bus.dec_mode = '0;
      bus.pos_clr  = '0;
      bus.flag_clr = '0;
      sys_rst_n    = 1'b0;

      repeat (3) @(negedge sys_clk);
      chk("rst_position", int'(bus.position), 0);
      chk("rst_flags", int'({bus.err_flag, bus.ovf_flag, bus.z_flag, bus.dir}), 0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      for (int v = 0; v < 8; v++) begin
         bus.dec_mode[1:0] = vecs[v].mode;
         bus.dir_inv[0]    = vecs[v].inv;
         if (vecs[v].clr) pulse_pos_clr(0);
         steps(0, vecs[v].n);
         chk($sformatf("vec%0d_pos", v), pos_of(0), vecs[v].exp_pos);
         chk($sformatf("vec%0d_dir", v), int'(bus.dir[0]), vecs[v].exp_dir);
         chk($sformatf("vec%0d_err", v), int'(bus.err_flag[0]), 0);
      end
      bus.dec_mode[1:0] = 2'b00;
      bus.dir_inv[0]    = 1'b0;
      pulse_pos_clr(0);

      // 8-cycle glitch on A is rejected.
      bus.enc_a[0] = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         @(negedge sys_clk);
         if (e == 8) bus.enc_a[0] = 1'b0;
      end
      chk("glitch8_pos", pos_of(0), 0);

      // 9-cycle pulse counts at edge 11, its trailing edge counts back at edge 20.
      bus.enc_a[0] = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         @(negedge sys_clk);
         if (e == 9)  bus.enc_a[0] = 1'b0;
         if (e == 10) chk("glitch9_e10", pos_of(0), 0);
         if (e == 11) chk("glitch9_e11", pos_of(0), 1);
         if (e == 19) chk("glitch9_e19", pos_of(0), 1);
         if (e == 20) chk("glitch9_e20", pos_of(0), 0);
      end

      // Wrap at the 8-bit boundaries.
      pulse_pos_clr(0);
      steps(0, 127);
      chk("ovf_pre_pos", pos_of(0), 127);
      chk("ovf_pre_flag", int'(bus.ovf_flag[0]), 0);
      steps(0, 1);
      chk("ovf_up_pos", pos_of(0), -128);
      chk("ovf_up_flag", int'(bus.ovf_flag[0]), 1);
      pulse_flag_clr(0);
      chk("ovf_clr_flag", int'(bus.ovf_flag[0]), 0);
      steps(0, -1);
      chk("ovf_dn_pos", pos_of(0), 127);
      chk("ovf_dn_flag", int'(bus.ovf_flag[0]), 1);
      pulse_flag_clr(0);

      // Index capture with clear.
      pulse_pos_clr(0);
      steps(0, 57);
      chk("z_pre_pos", pos_of(0), 57);
      bus.z_clr_en[0] = 1'b1;
      bus.enc_z[0]    = 1'b1;
      repeat (12) @(negedge sys_clk);
      bus.enc_z[0]    = 1'b0;
      repeat (12) @(negedge sys_clk);
      chk("z_capture", zcap_of(0), 57);
      chk("z_pos", pos_of(0), 0);
      chk("z_flag", int'(bus.z_flag[0]), 1);
      pulse_flag_clr(0);
      chk("z_flag_clr", int'(bus.z_flag[0]), 0);

      // Index edge and pos_clr edge land on the same cycle (edge 11).
      bus.z_clr_en[0] = 1'b0;
      steps(0, 5);
      chk("zpc_pre_pos", pos_of(0), 5);
      bus.enc_z[0] = 1'b1;
      repeat (9) @(negedge sys_clk);
      bus.pos_clr[0] = 1'b1;
      repeat (3) @(negedge sys_clk);
      bus.pos_clr[0] = 1'b0;
      bus.enc_z[0]   = 1'b0;
      repeat (12) @(negedge sys_clk);
      chk("zpc_capture", zcap_of(0), 5);
      chk("zpc_pos", pos_of(0), 0);

      // Disabled channel holds.
      bus.ch_en[1] = 1'b0;
      steps(1, 4);
      chk("chen_pos", pos_of(1), 0);
      bus.ch_en[1] = 1'b1;

      // Simultaneous A/B change on ch2.
      steps(2, 4);
      chk("err_pre_pos", pos_of(2), 4);
      st[2] = 2;
      drive_ab(2);
      repeat (14) @(negedge sys_clk);
      chk("err_flag2", int'(bus.err_flag[2]), 1);
      chk("err_pos2", pos_of(2), 4);
      chk("err_others", int'(bus.err_flag & 4'b1011), 0);
      chk("err_pos0", pos_of(0), 0);

      // Reset in the middle of a sequence.
      step(3, 1);
      step(3, 1);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_position", int'(bus.position), 0);
      chk("mid_rst_zcap", int'(bus.z_capture), 0);
      chk("mid_rst_flags", int'({bus.err_flag, bus.ovf_flag, bus.z_flag, bus.dir}), 0);
      bus.enc_a = '0;
      bus.enc_b = '0;
      bus.enc_z = '0;
      for (int c = 0; c < CH; c++) st[c] = 0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      bus.enc_a[0] = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         @(negedge sys_clk);
         if (e == 10) chk("post_rst_e10", pos_of(0), 0);
         if (e == 11) chk("post_rst_e11", pos_of(0), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
